// File: rtl/basys_input_reader_if.sv
// Data-memory read bus between the processor and the input-port register window.
interface basys_input_reader_if;
  logic [31:0] ReadAdr;
  logic        ReadEn;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output ReadAdr, ReadEn, input ReadData, hit);
  modport slave  (input ReadAdr, ReadEn, output ReadData, hit);
endinterface

// File: rtl/basys_input_reader.sv
// Basys3 input port: synchronized switches, debounced buttons and sticky press flags
// exposed as three read-only words beside the data memory.
module basys_input_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADR        = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          sw,
  input  logic [4:0]           btn,
  basys_input_reader_if.slave  bus
);

  localparam int unsigned    CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]   sw_m, sw_s;
  logic [4:0]    btn_m, btn_s, btn_db, db_next;
  logic [4:0]    press, press_next, rise, clr_mask;
  logic [CW-1:0] cnt      [5];
  logic [CW-1:0] cnt_next [5];
  logic [31:0]   rd_word;
  logic          sel_press;

  // Counter only runs while the synchronized input disagrees with the accepted state.
  always_comb begin
    db_next  = btn_db;
    cnt_next = cnt;
    for (int unsigned i = 0; i < 5; i++) begin
      if (btn_s[i] == btn_db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        db_next[i]  = btn_s[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    bus.hit = (bus.ReadAdr[31:4] == BASE_ADR[31:4]) &&
              (bus.ReadAdr[3:2] != 2'b11) &&
              (bus.ReadAdr[1:0] == 2'b00);
    rd_word = '0;
    case (bus.ReadAdr[3:2])
      2'b00:   rd_word = {16'b0, sw_s};
      2'b01:   rd_word = {27'b0, btn_db};
      2'b10:   rd_word = {27'b0, press};
      default: rd_word = '0;
    endcase
    bus.ReadData = bus.hit ? rd_word : '0;
  end

  // Clear only what the load returned; a new rising edge on the same cycle survives.
  always_comb begin
    sel_press  = bus.hit && (bus.ReadAdr[3:2] == 2'b10);
    rise       = db_next & ~btn_db;
    clr_mask   = (bus.ReadEn && sel_press) ? press : '0;
    press_next = (press & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_m   <= '0;
      sw_s   <= '0;
      btn_m  <= '0;
      btn_s  <= '0;
      btn_db <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sw_m   <= sw;
      sw_s   <= sw_m;
      btn_m  <= btn;
      btn_s  <= btn_m;
      btn_db <= db_next;
      press  <= press_next;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_basys_input_reader.sv
// Directed plus randomized checks of the input-port window against a sample-history model.
module tb_basys_input_reader;
  localparam int unsigned D    = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;

  basys_input_reader_if bus ();

  basys_input_reader #(.DEBOUNCE_CYCLES(D), .BASE_ADR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .btn (btn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: raw inputs appear two edges late; a button flips once its
  // last D synchronized samples all disagree with the accepted level.
  logic [15:0] m_sw_d1, m_sw_s;
  logic [4:0]  m_btn_d1, m_btn_s, m_db, m_press;
  logic [4:0]  hist [$];

  task automatic model_reset();
    m_sw_d1 = '0; m_sw_s = '0;
    m_btn_d1 = '0; m_btn_s = '0;
    m_db = '0; m_press = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [4:0] new_db, clr;
    bit all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_back(m_btn_s);
    if (hist.size() > D) void'(hist.pop_front());
    new_db = m_db;
    if (hist.size() == D) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) new_db[b] = ~m_db[b];
      end
    end
    clr      = (bus.ReadEn && bus.ReadAdr == BASE + 32'h8) ? m_press : 5'b0;
    m_press  = (m_press & ~clr) | (new_db & ~m_db);
    m_db     = new_db;
    m_sw_s   = m_sw_d1;  m_sw_d1  = sw;
    m_btn_s  = m_btn_d1; m_btn_d1 = btn;
  endtask

  function automatic logic exp_hit(logic [31:0] a);
    return (a == BASE) || (a == BASE + 32'h4) || (a == BASE + 32'h8);
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    if (a == BASE)               return {16'b0, m_sw_s};
    else if (a == BASE + 32'h4)  return {27'b0, m_db};
    else if (a == BASE + 32'h8)  return {27'b0, m_press};
    else                         return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present an address, compare against the model, optionally also a fixed value.
  task automatic rd(input logic [31:0] a, input logic en, input string tag,
                    input bit use_k = 1'b0, input logic [31:0] k = '0);
    bus.ReadAdr = a;
    bus.ReadEn  = en;
    #1;
    check({tag, "_data"}, bus.ReadData, exp_rd(a));
    check({tag, "_hit"}, {31'b0, bus.hit}, {31'b0, exp_hit(a)});
    if (use_k) check({tag, "_const"}, bus.ReadData, k);
  endtask

  task automatic idle();
    bus.ReadEn  = 1'b0;
    bus.ReadAdr = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adrs [6];
    adrs[0] = BASE; adrs[1] = BASE + 32'h4; adrs[2] = BASE + 32'h8;
    adrs[3] = BASE + 32'hC; adrs[4] = BASE + 32'h2; adrs[5] = 32'h200;

    // Reset with every input high
    rst = 1'b1; sw = 16'hFFFF; btn = 5'h1F; idle();
    model_reset();
    ticks(3);
    rd(BASE,        1'b0, "rst_sw",    1'b1, 32'h0);
    rd(BASE + 32'h4, 1'b0, "rst_btn",  1'b1, 32'h0);
    rd(BASE + 32'h8, 1'b0, "rst_press", 1'b1, 32'h0);
    #2; rst = 1'b0; btn = 5'h00; idle();
    tick();
    rd(BASE, 1'b0, "sw_lat1", 1'b1, 32'h0);
    tick();
    rd(BASE, 1'b0, "sw_lat2", 1'b1, 32'h0000_FFFF);
    idle(); ticks(4);

    // Debounce accept on btn[0]
    btn[0] = 1'b1;
    ticks(5);
    rd(BASE + 32'h4, 1'b0, "acc_e5", 1'b1, 32'h0);
    tick();
    rd(BASE + 32'h4, 1'b0, "acc_e6", 1'b1, 32'h1);
    rd(BASE + 32'h8, 1'b0, "acc_press", 1'b1, 32'h1);
    rd(BASE + 32'h8, 1'b1, "cor_read", 1'b1, 32'h1);
    tick(); idle();
    rd(BASE + 32'h8, 1'b0, "cor_after", 1'b1, 32'h0);

    // Release sets nothing
    btn[0] = 1'b0; idle();
    ticks(8);
    rd(BASE + 32'h4, 1'b0, "rel_db", 1'b1, 32'h0);
    rd(BASE + 32'h8, 1'b0, "rel_press", 1'b1, 32'h0);

    // Glitch of 3 samples on btn[2]
    btn[2] = 1'b1; idle(); ticks(3);
    btn[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd(BASE + 32'h4, 1'b0, "gl_db", 1'b1, 32'h0);
      rd(BASE + 32'h8, 1'b0, "gl_press", 1'b1, 32'h0);
      idle();
    end

    // Set/clear collision: press[2] pending, btn_db[1] rises on the clearing edge
    btn[2] = 1'b1; ticks(6);
    rd(BASE + 32'h8, 1'b0, "col_pre", 1'b1, 32'h4);
    idle();
    btn[1] = 1'b1; ticks(5);
    rd(BASE + 32'h8, 1'b1, "col_read", 1'b1, 32'h4);
    tick(); idle();
    rd(BASE + 32'h8, 1'b0, "col_after", 1'b1, 32'h2);

    // Decode holes and non-clearing reads
    rd(BASE + 32'hC, 1'b0, "dec_10c", 1'b1, 32'h0);
    rd(BASE + 32'h2, 1'b0, "dec_102", 1'b1, 32'h0);
    rd(32'h200,      1'b0, "dec_200", 1'b1, 32'h0);
    rd(BASE + 32'h4, 1'b1, "en_104"); tick();
    rd(BASE + 32'hC, 1'b1, "en_10c"); tick(); idle();
    rd(BASE + 32'h8, 1'b0, "keep_press", 1'b1, 32'h2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sw = 16'($urandom);
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 4)] ^= 1'b1;
      rd(adrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), "rand");
      tick();
    end
    idle();

    // Async reset mid-debounce on btn[3]
    btn = 5'h00; ticks(10);
    rd(BASE + 32'h4, 1'b0, "pre_rst_db", 1'b1, 32'h0);
    btn[3] = 1'b1; ticks(4);
    #2; rst = 1'b1; model_reset();
    #1; rd(BASE + 32'h4, 1'b0, "mid_rst", 1'b1, 32'h0);
    tick();
    #2; rst = 1'b0;
    ticks(5);
    rd(BASE + 32'h4, 1'b0, "post_rst_e5", 1'b1, 32'h0);
    tick();
    rd(BASE + 32'h4, 1'b0, "post_rst_e6", 1'b1, 32'h8);
    rd(BASE + 32'h8, 1'b0, "post_rst_press", 1'b1, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
